seg7_scan_driver: RTL
=====================

// Module: seg7_scan_driver
// PURPOSE
//   Downstream display stage for the 8-bit free-running counter.
//   Accepts a count value over a valid/ready handshake and shows it as two hex digits
//   on one time-multiplexed 7-segment bus with per-digit enables.
//   Includes prescaled refresh, anti-ghost guard slots, tear-free frame-boundary update,
//   leading-zero blanking and wrap indication on the decimal point.
// PARAMETERS
//   REFRESH_DIV  1000  clock cycles each digit is lit per slot (>=2)
//   GUARD_CYC    4     clock cycles all digits dark between slots (>=1)
//   DIV_W        16    prescaler width; must hold max(REFRESH_DIV,GUARD_CYC)-1
//   BLANK_LZ     1     1: blank high digit when its nibble is 0
//   ACTIVE_LOW   0     1: invert seg_o, dp_o, dig_en_o at the output register
// PORTS
//   clk            in   1  clock
//   rst_n          in   1  reset
//   value_i        in   8  count value to display
//   value_valid_i  in   1  value_i valid
//   value_ready_o  out  1  block can accept value_i this cycle
//   seg_o          out  7  segments {g,f,e,d,c,b,a}; seg_o[0]=a
//   dp_o           out  1  decimal point
//   dig_en_o       out  2  digit enables; [0]=low nibble, [1]=high nibble
//   frame_o        out  1  one-cycle pulse at each frame boundary
// BEHAVIOUR
//   Reset: rst_n is synchronous, active-low; clock is clk.
//     - State is SHOW0 with prescaler 0.
//     - Display register and pending buffer are cleared; wrap flag is 0.
//     - Outputs: seg_o=0, dp_o=0, dig_en_o=0 and frame_o=0, all-ones where ACTIVE_LOW inverts.
//     - value_ready_o=1.
//   FSM: SHOW0 -> GUARD0 -> SHOW1 -> GUARD1 -> SHOW0.
//     - SHOW states last REFRESH_DIV cycles; GUARD states last GUARD_CYC cycles.
//     - The prescaler counts 0..N-1, then clears as the state advances.
//     - Frame length = 2*(REFRESH_DIV+GUARD_CYC).
//   Frame boundary: the last cycle of GUARD1.
//   Handshake: a transfer occurs when value_valid_i && value_ready_o.
//     - One-entry pending buffer.
//     - value_ready_o = !pend_full || boundary (combinational).
//     - Accepted data goes to the pending buffer; the newest accepted value wins.
//   At the boundary, when pend_full:
//     - display <= pending.
//     - wrap <= (pending < display).
//     - pend_full is cleared, unless a new value is accepted the same cycle.
//     - If a value is accepted that same cycle, the old pending value goes to display and the
//       new value fills pending.
//   At the boundary, when the pending buffer is empty:
//     - Display is unchanged.
//     - wrap <= 0.
//   Display never changes mid-frame (no tearing).
//   Decode: standard hex, 0-F ->
//     3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
//   Outputs are registered, with 1-cycle latency from state:
//     - SHOW0: dig_en=01, seg=dec(display[3:0]), dp=wrap.
//     - SHOW1: dig_en=10, seg=dec(display[7:4]), or 0 if BLANK_LZ and display[7:4]==0; dp=0.
//     - GUARD*: dig_en=00, seg=0, dp=0.
//   frame_o: high in the cycle after the boundary (registered).
//   Reset mid-frame: everything returns to reset values next cycle; pending data is lost.
//   value_i is ignored when value_valid_i=0; there is no X-propagation onto the outputs.
// TESTING  (REFRESH_DIV=4, GUARD_CYC=2, frame=12 cycles, ACTIVE_LOW=0)
//   1. Reset 3 cycles, then idle.
//      -> seg_o=00, dig_en_o=00 during reset.
//      -> Then a repeating pattern of 4x01, 2x00, 4x10, 2x00.
//      -> seg=3F on digit 0; seg=00 on digit 1 (blanked); frame_o every 12 cycles.
//   2. Send 8'hA5 mid-SHOW0.
//      -> Display stays 00 until the boundary.
//      -> Next frame: digit0 seg=6D, digit1 seg=77, dp_o=0.
//   3. Send 8'h05 then 8'h07 in one frame (ready high both times, second overwrites pending).
//      -> Next frame digit0 seg=07; digit1 blanked (00); with BLANK_LZ=0, digit1 shows 3F.
//   4. Display=FF, then send 8'h00.
//      -> dp_o=1 during SHOW0 of the next frame only; cleared the following frame.
//   5. Fill pending (ready drops to 0); hold valid with 8'h12 until the boundary.
//      -> Accepted on the boundary cycle; old pending shown this frame; 12 shown next frame.
//   6. Assert rst_n=0 for 1 cycle mid-SHOW1 with pending full.
//      -> Next cycle all outputs are 0 and ready=1.
//      -> The following frame shows 00; the pending value is discarded.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: two-digit multiplexed hex display with guard slots and frame-boundary update
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 1000,
    parameter int GUARD_CYC   = 4,
    parameter int DIV_W       = 16,
    parameter bit BLANK_LZ    = 1'b1,
    parameter bit ACTIVE_LOW  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] value_i,
    input  logic       value_valid_i,
    output logic       value_ready_o,
    output logic [6:0] seg_o,
    output logic       dp_o,
    output logic [1:0] dig_en_o,
    output logic       frame_o
);
    typedef enum logic [1:0] {SHOW0, GUARD0, SHOW1, GUARD1} state_t;

    localparam logic [6:0] HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    state_t           state;
    logic [DIV_W-1:0] div;
    logic [7:0]       disp;
    logic [7:0]       pend;
    logic             pend_full;
    logic             wrap;
    logic             show;
    logic             last;
    logic             boundary;
    logic             accept;
    logic [6:0]       seg_n;
    logic [1:0]       dig_n;
    logic             dp_n;

    assign show          = (state == SHOW0) || (state == SHOW1);
    assign last          = div == (show ? DIV_W'(REFRESH_DIV - 1) : DIV_W'(GUARD_CYC - 1));
    assign boundary      = (state == GUARD1) && last;
    assign value_ready_o = !pend_full || boundary;
    assign accept        = value_valid_i && value_ready_o;

    // Next output values derived from the current slot; high digit may be blanked
    always_comb begin
        dig_n = (state == SHOW0) ? 2'b01 : (state == SHOW1) ? 2'b10 : 2'b00;
        seg_n = (state == SHOW0) ? HEX[disp[3:0]] :
                ((state == SHOW1) && !(BLANK_LZ && disp[7:4] == 4'h0)) ? HEX[disp[7:4]] : 7'h00;
        dp_n  = (state == SHOW0) && wrap;
    end

    // Slot sequencer, pending buffer, frame-boundary display update and output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= SHOW0;
            div       <= '0;
            disp      <= '0;
            pend      <= '0;
            pend_full <= 1'b0;
            wrap      <= 1'b0;
            seg_o     <= {7{ACTIVE_LOW}};
            dp_o      <= ACTIVE_LOW;
            dig_en_o  <= {2{ACTIVE_LOW}};
            frame_o   <= 1'b0;
        end else begin
            div   <= last ? '0 : div + 1'b1;
            state <= !last ? state :
                     (state == SHOW0)  ? GUARD0 :
                     (state == GUARD0) ? SHOW1  :
                     (state == SHOW1)  ? GUARD1 : SHOW0;
            if (boundary && pend_full) begin
                disp <= pend;
                wrap <= pend < disp;
            end else if (boundary) begin
                wrap <= 1'b0;
            end
            if (accept) begin
                pend      <= value_i;
                pend_full <= 1'b1;
            end else if (boundary) begin
                pend_full <= 1'b0;
            end
            seg_o    <= {7{ACTIVE_LOW}} ^ seg_n;
            dp_o     <= ACTIVE_LOW ^ dp_n;
            dig_en_o <= {2{ACTIVE_LOW}} ^ dig_n;
            frame_o  <= boundary;
        end
    end
endmodule
